// File: rtl/wide_alu_seq.sv
// -----------------------------------------------------------------------------
// wide_alu_seq
//
// Runs 8*NBYTES-bit ADD / AND / OR / XOR / SHL operations through an external
// 8-bit combinational ALU. One byte is processed per cycle, LSB byte first,
// and the ALU carry is chained from byte to byte. A start/busy/done handshake
// tells the caller when the wide result is ready.
//
// Parameters:
//   NBYTES   operand width in bytes (>= 2)
//   ALU_ADD  ALU opcode for add-with-carry (5'h07)
//   ALU_AND  ALU opcode for bitwise AND    (5'h04)
//   ALU_OR   ALU opcode for bitwise OR     (5'h03)
//   ALU_XOR  ALU opcode for bitwise XOR    (5'h02)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   operation request, sampled only while idle
//   op[2:0]      in   0=ADD 1=AND 2=OR 3=XOR 4=SHL, 5..7 are ignored
//   a_in, b_in   in   wide operands (b_in is not used by SHL)
//   cin          in   carry-in for ADD, shift-in bit for SHL
//   busy         out  an operation is in progress
//   done         out  one-cycle pulse; result/cout/zero are valid
//   result       out  wide result, held until the next accepted start
//   cout         out  final carry (ADD) or shifted-out bit (SHL), 0 for logic ops
//   zero         out  result == 0
//   alu_a/alu_b  out  byte operands to the ALU
//   alu_op       out  ALU opcode
//   alu_sc_in    out  carry into the ALU
//   alu_out      in   ALU byte result
//   alu_sc_out   in   ALU carry-out
//   alu_zero     in   ALU zero flag (not used here)
//
// Build option:
//   WIDE_ALU_SEQ_FAST_DONE_EN  removes the DONE state. done, cout and zero are
//   updated on the edge that writes the last byte, and the FSM goes straight
//   back to idle.
// -----------------------------------------------------------------------------
module wide_alu_seq #(
  parameter int         NBYTES  = 2,
  parameter logic [4:0] ALU_ADD = 5'h07,
  parameter logic [4:0] ALU_AND = 5'h04,
  parameter logic [4:0] ALU_OR  = 5'h03,
  parameter logic [4:0] ALU_XOR = 5'h02
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                zero,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [4:0]          alu_op,
  output logic                alu_sc_in,
  input  logic [7:0]          alu_out,
  input  logic                alu_sc_out,
  input  logic                alu_zero
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifndef WIDE_ALU_SEQ_FAST_DONE_EN
  localparam logic [1:0] S_DONE = 2'd2;
`endif

  logic [1:0]      state_q,  state_d;
  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic [2:0]      op_q,     op_d;
  logic [IDXW-1:0] idx_q,    idx_d;
  logic            carry_q,  carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q,   cout_d;
  logic            zero_q,   zero_d;
  logic            done_q,   done_d;

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       op_is_arith;

  // The ALU zero flag is not needed: zero is computed over the whole result.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign a_byte      = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte      = b_q[{idx_q, 3'b000} +: 8];
  // Only ADD and SHL chain carry between bytes; logic ops always restart at 0.
  assign op_is_arith = (op_q == OP_ADD) || (op_q == OP_SHL);

  // ALU drive: active only while running, quiet (all zero) otherwise.
  always_comb begin
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = 5'h00;
    alu_sc_in = 1'b0;
    if (state_q == S_RUN) begin
      alu_a     = a_byte;
      alu_sc_in = carry_q;
      case (op_q)
        OP_ADD: begin alu_b = b_byte; alu_op = ALU_ADD; end
        OP_AND: begin alu_b = b_byte; alu_op = ALU_AND; end
        OP_OR:  begin alu_b = b_byte; alu_op = ALU_OR;  end
        OP_XOR: begin alu_b = b_byte; alu_op = ALU_XOR; end
        // A + A + carry is a one-bit left shift with carry as the shift-in bit.
        OP_SHL: begin alu_b = a_byte; alu_op = ALU_ADD; end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every _d starts from its _q (done from 0) so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (op <= OP_SHL)) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op;
          idx_d   = '0;
          carry_d = ((op == OP_ADD) || (op == OP_SHL)) ? cin : 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // NOTE: blocking assignments here let result_d and carry_d be reused
        // below in the same pass to build the final flags.
        result_d[{idx_q, 3'b000} +: 8] = alu_out;
        carry_d = op_is_arith ? alu_sc_out : 1'b0;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef WIDE_ALU_SEQ_FAST_DONE_EN
          done_d  = 1'b1;
          cout_d  = carry_d;
          zero_d  = (result_d == '0);
          state_d = S_IDLE;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

`ifndef WIDE_ALU_SEQ_FAST_DONE_EN
      S_DONE: begin
        done_d  = 1'b1;
        cout_d  = carry_q;
        zero_d  = (result_q == '0);
        state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, operands included, is cleared by the asynchronous
  // reset so a partial operation leaves nothing behind; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule
